// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register: next-PC select, imem access, 1-cycle fetch->decode latency.
// Backpressure: stallF holds the PC, stallD holds IF/ID; flush_except overrides both stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        flush_except,
    input  logic [31:0] newpc,
    input  logic        jrD,
    input  logic [31:0] jr_targetD,
    input  logic        jumpD,
    input  logic [31:0] jump_targetD,
    input  logic        branch_takenD,
    input  logic [31:0] branch_targetD,
    input  logic        ctrl_flowD,
    output logic        inst_en,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD,
    output logic        delayslotD,
    output logic        adelD
);

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic        valid_d_q, valid_d_d;
    logic        delayslot_d_q, delayslot_d_d;
    logic        adel_d_q, adel_d_d;
    logic        adel_f;

    assign adel_f = (pc_f_q[1:0] != 2'b00);

    always_comb begin
        pc_f_d = pc_f_q + 32'd4;
        if (rst)
            pc_f_d = RESET_PC;
        else if (flush_except)
            pc_f_d = newpc;
        else if (stallF)
            pc_f_d = pc_f_q;
        else if (jrD)
            pc_f_d = jr_targetD;
        else if (jumpD)
            pc_f_d = jump_targetD;
        else if (branch_takenD)
            pc_f_d = branch_targetD;
    end

    // A misaligned fetch never reaches memory; it travels to decode as a null word with adelD set.
    always_comb begin
        instr_d_d     = adel_f ? 32'h0 : inst_rdata;
        pc_d_d        = pc_f_q;
        valid_d_d     = 1'b1;
        delayslot_d_d = ctrl_flowD;
        adel_d_d      = adel_f;
        if (rst || flush_except || (!stallD && flushD)) begin
            instr_d_d     = 32'h0;
            pc_d_d        = 32'h0;
            valid_d_d     = 1'b0;
            delayslot_d_d = 1'b0;
            adel_d_d      = 1'b0;
        end else if (stallD) begin
            instr_d_d     = instr_d_q;
            pc_d_d        = pc_d_q;
            valid_d_d     = valid_d_q;
            delayslot_d_d = delayslot_d_q;
            adel_d_d      = adel_d_q;
        end
    end

    always_ff @(posedge clk) begin
        pc_f_q        <= pc_f_d;
        instr_d_q     <= instr_d_d;
        pc_d_q        <= pc_d_d;
        valid_d_q     <= valid_d_d;
        delayslot_d_q <= delayslot_d_d;
        adel_d_q      <= adel_d_d;
    end

    assign inst_en    = ~rst & ~adel_f & ~flush_except;
    assign inst_addr  = pc_f_q;
    assign pcF        = pc_f_q;
    assign instrD     = instr_d_q;
    assign pcD        = pc_d_q;
    assign validD     = valid_d_q;
    assign delayslotD = delayslot_d_q;
    assign adelD      = adel_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential flow, branch delay slot, stalls, redirects, address error.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallF, stallD, flushD, flush_except;
    logic [31:0] newpc;
    logic        jrD, jumpD, branch_takenD, ctrl_flowD;
    logic [31:0] jr_targetD, jump_targetD, branch_targetD;
    logic        inst_en;
    logic [31:0] inst_addr, inst_rdata, pcF, instrD, pcD;
    logic        validD, delayslotD, adelD;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    assign inst_rdata = mem_word(inst_addr);

    fetch_stage #(.RESET_PC(BASE)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .flush_except(flush_except), .newpc(newpc),
        .jrD(jrD), .jr_targetD(jr_targetD), .jumpD(jumpD), .jump_targetD(jump_targetD),
        .branch_takenD(branch_takenD), .branch_targetD(branch_targetD), .ctrl_flowD(ctrl_flowD),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .pcF(pcF), .instrD(instrD), .pcD(pcD), .validD(validD),
        .delayslotD(delayslotD), .adelD(adelD)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; stallF = 0; stallD = 0; flushD = 0; flush_except = 0;
        jrD = 0; jumpD = 0; branch_takenD = 0; ctrl_flowD = 0;
    endtask

    initial begin
        quiet();
        newpc = 0; jr_targetD = 0; jump_targetD = 0; branch_targetD = 0;
        rst = 1;
        step();
        step();
        chk("rst_pcF", pcF, BASE);
        chk("rst_instrD", instrD, 32'h0);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_validD", {31'b0, validD}, 32'd0);
        chk("rst_dsD", {31'b0, delayslotD}, 32'd0);
        chk("rst_adelD", {31'b0, adelD}, 32'd0);
        chk("rst_inst_en", {31'b0, inst_en}, 32'd0);
        rst = 0;
        #1;
        chk("run_inst_en", {31'b0, inst_en}, 32'd1);
        chk("inst_addr", inst_addr, BASE);

        // Sequential flow: pcD trails pcF by one fetch.
        step();
        chk("seq1_pcF", pcF, BASE + 32'h4);
        chk("seq1_pcD", pcD, BASE);
        chk("seq1_validD", {31'b0, validD}, 32'd1);
        chk("seq1_instrD", instrD, mem_word(BASE));
        for (int k = 2; k <= 5; k++) step();
        chk("seq5_pcF", pcF, BASE + 32'h14);
        chk("seq5_pcD", pcD, BASE + 32'h10);
        chk("seq5_instrD", instrD, mem_word(BASE + 32'h10));

        // Taken branch in decode: delay slot at 0x14 still fetched, then target.
        branch_takenD = 1; ctrl_flowD = 1; branch_targetD = BASE + 32'h100;
        step();
        quiet();
        chk("br_pcF", pcF, BASE + 32'h100);
        chk("br_ds_pcD", pcD, BASE + 32'h14);
        chk("br_ds_flag", {31'b0, delayslotD}, 32'd1);
        step();
        chk("br_tgt_pcD", pcD, BASE + 32'h100);
        chk("br_tgt_ds", {31'b0, delayslotD}, 32'd0);
        chk("br_tgt_pcF", pcF, BASE + 32'h104);

        // Full stall with flushD and ctrl_flowD asserted: nothing moves.
        stallF = 1; stallD = 1; flushD = 1; ctrl_flowD = 1;
        for (int k = 0; k < 3; k++) step();
        chk("stall_pcF", pcF, BASE + 32'h104);
        chk("stall_pcD", pcD, BASE + 32'h100);
        chk("stall_instrD", instrD, mem_word(BASE + 32'h100));
        chk("stall_validD", {31'b0, validD}, 32'd1);
        chk("stall_ds", {31'b0, delayslotD}, 32'd0);
        quiet();
        step();
        chk("resume_pcD", pcD, BASE + 32'h104);
        chk("resume_instrD", instrD, mem_word(BASE + 32'h104));
        chk("resume_pcF", pcF, BASE + 32'h108);

        // flushD alone inserts a bubble while fetch advances.
        flushD = 1;
        step();
        quiet();
        chk("flushD_validD", {31'b0, validD}, 32'd0);
        chk("flushD_pcD", pcD, 32'h0);
        chk("flushD_instrD", instrD, 32'h0);
        chk("flushD_pcF", pcF, BASE + 32'h10C);
        step();
        chk("postflush_pcD", pcD, BASE + 32'h10C);

        // Exception redirect overrides both stalls.
        flush_except = 1; newpc = BASE + 32'h380; stallF = 1; stallD = 1;
        #1;
        chk("exc_inst_en", {31'b0, inst_en}, 32'd0);
        step();
        quiet();
        chk("exc_pcF", pcF, BASE + 32'h380);
        chk("exc_validD", {31'b0, validD}, 32'd0);
        chk("exc_instrD", instrD, 32'h0);
        step();
        chk("exc_next_pcD", pcD, BASE + 32'h380);
        chk("exc_next_pcF", pcF, BASE + 32'h384);

        // Plain jump.
        jumpD = 1; jump_targetD = BASE + 32'h400;
        step();
        quiet();
        chk("j_pcF", pcF, BASE + 32'h400);

        // All three redirects at once: jr wins, and its target is misaligned.
        jrD = 1; jumpD = 1; branch_takenD = 1;
        jr_targetD = BASE + 32'h102; jump_targetD = BASE + 32'h500; branch_targetD = BASE + 32'h600;
        step();
        quiet();
        chk("prio_pcF", pcF, BASE + 32'h102);
        chk("adel_inst_en", {31'b0, inst_en}, 32'd0);
        step();
        chk("adel_flag", {31'b0, adelD}, 32'd1);
        chk("adel_instrD", instrD, 32'h0);
        chk("adel_pcD", pcD, BASE + 32'h102);
        chk("adel_validD", {31'b0, validD}, 32'd1);

        // PC wraps past the top of the address space.
        flush_except = 1; newpc = 32'hFFFF_FFFC;
        step();
        quiet();
        step();
        chk("wrap_pcF", pcF, 32'h0);
        chk("wrap_pcD", pcD, 32'hFFFF_FFFC);

        // Reset beats stalls and a pending redirect.
        rst = 1; stallF = 1; stallD = 1; jrD = 1; flush_except = 1;
        step();
        chk("rst_mid_pcF", pcF, BASE);
        chk("rst_mid_validD", {31'b0, validD}, 32'd0);
        chk("rst_mid_pcD", pcD, 32'h0);
        quiet();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL: parameter RESET_PC, default 32'hBFC0_0000, PC loaded on reset.
REQ-002 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL: stallF  input  1  hold PC register.
REQ-005 SHALL: stallD  input  1  hold IF/ID register.
REQ-006 SHALL: flushD  input  1  clear IF/ID register (pipeline bubble).
REQ-007 SHALL: flush_except  input  1  exception/ERET redirect; overrides all stalls.
REQ-008 SHALL: newpc  input  32  redirect target when flush_except=1 (handler entry or EPC).
REQ-009 SHALL: jrD  input  1  JR/JALR in decode; target jr_targetD.
REQ-010 SHALL: jr_targetD  input  32  register-sourced target.
REQ-011 SHALL: jumpD  input  1  J/JAL in decode; target jump_targetD.
REQ-012 SHALL: jump_targetD  input  32  {pcD+4[31:28], instr_index, 2'b00}.
REQ-013 SHALL: branch_takenD  input  1  resolved taken branch (incl. BAL forms) in decode.
REQ-014 SHALL: branch_targetD  input  32  branch target.
REQ-015 SHALL: ctrl_flowD  input  1  decode holds any branch/jump (taken or not); marks next fetched instruction as delay slot.
REQ-016 SHALL: inst_en  output  1  instruction memory enable.
REQ-017 SHALL: inst_addr  output  32  fetch address, equals pcF.
REQ-018 SHALL: inst_rdata  input  32  instruction word, combinational from inst_addr.
REQ-019 SHALL: pcF  output  32  current fetch PC.
REQ-020 SHALL: instrD  output  32  decode-stage instruction.
REQ-021 SHALL: pcD  output  32  decode-stage PC.
REQ-022 SHALL: validD  output  1  decode slot holds a real instruction.
REQ-023 SHALL: delayslotD  output  1  decode instruction sits in a delay slot.
REQ-024 SHALL: adelD  output  1  fetch address error (pcD[1:0]!=0); pcD is BadVAddr.

Function
REQ-025 SHALL: next-PC priority: rst -> RESET_PC; flush_except -> newpc; stallF -> hold; jrD -> jr_targetD; jumpD -> jump_targetD; branch_takenD -> branch_targetD; else pcF+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-026 SHALL: flush_except load newpc even with stallF=1.
REQ-027 SHALL: redirect on jrD/jumpD/branch_takenD take effect next cycle; instruction concurrently in F (delay slot) is not squashed.
REQ-028 SHALL: inst_en = ~rst & ~adelF & ~flush_except, adelF = (pcF[1:0]!=2'b00).
REQ-029 SHALL: IF/ID update priority: rst or flush_except -> clear; stallD -> hold all fields; flushD -> clear; else load.
REQ-030 SHALL: clear means instrD=0, pcD=0, validD=0, delayslotD=0, adelD=0.
REQ-031 SHALL: load means instrD = adelF ? 32'h0 : inst_rdata, pcD=pcF, validD=1, delayslotD=ctrl_flowD, adelD=adelF.
REQ-032 SHALL: stallD=1 with flushD=1 hold (stall wins); flush_except still clears.
REQ-033 SHALL: stallF=0 with stallD=1 not occur from hazard unit; if it does, PC advances and the fetched word is dropped (no requirement to preserve it).
REQ-034 SHALL: latency fetch->decode exactly 1 cycle absent stalls; throughput 1 instr/cycle.
REQ-035 SHALL: ctrl_flowD sampled at load cycle only; held value not re-evaluated during stallD.

Reset
REQ-036 SHALL: after rst cycle: pcF=RESET_PC, instrD=0, pcD=0, validD=0, delayslotD=0, adelD=0; inst_en=0 while rst=1.
REQ-037 SHALL: rst asserted mid-stall or mid-redirect override all other inputs in that cycle.

Verification
REQ-038 SHALL: release rst, no stalls, rdata=addr-derived -> pcF 0xBFC00000,04,08...; pcD trails pcF by one cycle, validD=1 from 2nd cycle.
REQ-039 SHALL: BEQ at pcD=0xBFC00010, branch_takenD=1, ctrl_flowD=1, target 0xBFC00100 -> next pcD=0xBFC00014 with delayslotD=1, then pcD=0xBFC00100, delayslotD=0.
REQ-040 SHALL: stallF=stallD=1 for 3 cycles with flushD=1 -> pcF, instrD, pcD unchanged; after release flow resumes without loss or duplication.
REQ-041 SHALL: flush_except=1, newpc=0xBFC00380, stallF=stallD=1 -> next cycle pcF=0xBFC00380, validD=0, instrD=0.
REQ-042 SHALL: jr_targetD=0xBFC00102 with jrD=1 -> pcF=0xBFC00102, inst_en=0; next cycle adelD=1, instrD=0, pcD=0xBFC00102.
REQ-043 SHALL: jrD=jumpD=branch_takenD=1 same cycle -> pcF takes jr_targetD.
